id_issue_queue: RTL and testbench

Parametrised instruction buffer and dual-issue judge between fetch and decode. Each cycle it accepts up to FETCH_W fetched instructions, each carrying its PC and 14-bit exception vector, into a circular queue. It presents the oldest one or two entries to the two decode pipelines, applying the pairing rules below. Flush empties the queue in one cycle on redirect or exception.

---
 rtl/id_issue_queue.sv | 163 ++++++++++++++++
 tb/tb_id_issue_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// Instruction buffer between fetch and decode: a circular queue filled up to
// FETCH_W lanes per cycle, drained one or two entries per cycle under dual-issue pairing rules.
module id_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [FETCH_W-1:0]      enq_valid,
  input  logic [32*FETCH_W-1:0]   enq_instr,
  input  logic [32*FETCH_W-1:0]   enq_pc,
  input  logic [14*FETCH_W-1:0]   enq_exp,
  output logic                    enq_ready,
  input  logic                    issue_ready,
  output logic [1:0]              issue_valid,
  output logic [31:0]             Instr_First,
  output logic [31:0]             PC_First,
  output logic [13:0]             Exp_First,
  output logic [31:0]             Instr_Second,
  output logic [31:0]             PC_Second,
  output logic [13:0]             Exp_Second,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [13:0]   exp_mem_r   [DEPTH];

  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  logic [AW-1:0] next_ptr_s;
  logic [CW-1:0] free_s;
  logic          enq_fire_s;
  logic          run_s;
  logic [FETCH_W-1:0] lane_we_s;
  logic [AW-1:0] lane_addr_s [FETCH_W];
  logic [CW-1:0] enq_cnt_s;
  logic [CW-1:0] deq_cnt_s;
  logic          pair_block_s;
  logic [4:0]    first_dest_s;
  logic [1:0]    issue_valid_s;

  function automatic logic f_is_branch(input logic [31:0] ins);
    logic r;
    case (ins[31:26])
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: r = 1'b1;
      6'h00:   r = (ins[5:0] == 6'h08) || (ins[5:0] == 6'h09);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic f_is_trap(input logic [31:0] ins);
    logic r;
    case (ins[31:26])
      6'h10:   r = 1'b1;
      6'h00:   r = (ins[5:0] == 6'h0C) || (ins[5:0] == 6'h0D);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic f_is_hilo(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) && (ins[5:0] >= 6'h10) && (ins[5:0] <= 6'h1B);
  endfunction

  // Zero means no destination, which also covers writes to $0.
  function automatic logic [4:0] f_dest(input logic [31:0] ins);
    logic [4:0] d;
    case (ins[31:26])
      6'h00:   d = ins[15:11];
      6'h03:   d = 5'd31;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: d = ins[20:16];
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  assign next_ptr_s   = rd_ptr_r + AW'(1'b1);
  assign free_s       = CW'(DEPTH) - count_r;
  assign enq_ready    = free_s >= CW'(FETCH_W);
  assign enq_fire_s   = enq_ready && !flush;

  assign Instr_First  = instr_mem_r[rd_ptr_r];
  assign PC_First     = pc_mem_r[rd_ptr_r];
  assign Exp_First    = exp_mem_r[rd_ptr_r];
  assign Instr_Second = instr_mem_r[next_ptr_s];
  assign PC_Second    = pc_mem_r[next_ptr_s];
  assign Exp_Second   = exp_mem_r[next_ptr_s];
  assign count        = count_r;
  assign issue_valid  = issue_valid_s;

  // Lane write enables and addresses; only the contiguous run from lane 0 is taken.
  always_comb begin
    run_s     = 1'b1;
    enq_cnt_s = '0;
    lane_we_s = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      run_s          = run_s & enq_valid[i];
      lane_we_s[i]   = run_s & enq_fire_s;
      lane_addr_s[i] = wr_ptr_r + AW'(i);
      if (lane_we_s[i]) begin
        enq_cnt_s = enq_cnt_s + CW'(1'b1);
      end else begin
        enq_cnt_s = enq_cnt_s;
      end
    end
  end

  // Dual-issue judge on head and head+1.
  always_comb begin
    first_dest_s = f_dest(Instr_First);
    pair_block_s = f_is_trap(Instr_First) || f_is_trap(Instr_Second) ||
                   f_is_branch(Instr_Second) ||
                   (f_is_hilo(Instr_First) && f_is_hilo(Instr_Second)) ||
                   ((first_dest_s != 5'd0) &&
                    ((first_dest_s == Instr_Second[25:21]) ||
                     (first_dest_s == Instr_Second[20:16])));
    issue_valid_s[0] = count_r != CW'(1'b0);
    issue_valid_s[1] = (count_r >= CW'(2'd2)) && !pair_block_s;
    if (issue_ready && !flush) begin
      deq_cnt_s = CW'(issue_valid_s[0]) + CW'(issue_valid_s[1]);
    end else begin
      deq_cnt_s = '0;
    end
  end

  // Queue storage; deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (lane_we_s[i]) begin
        instr_mem_r[lane_addr_s[i]] <= enq_instr[32*i +: 32];
        pc_mem_r[lane_addr_s[i]]    <= enq_pc[32*i +: 32];
        exp_mem_r[lane_addr_s[i]]   <= enq_exp[14*i +: 14];
      end
    end
  end

  // Pointers and occupancy; flush overrides same-cycle enqueue and dequeue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + deq_cnt_s[AW-1:0];
      wr_ptr_r <= wr_ptr_r + enq_cnt_s[AW-1:0];
      count_r  <= count_r + enq_cnt_s - deq_cnt_s;
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: pairing-rule vector table plus hand sequences,
// with a queue scoreboard checking issued instructions in program order.
module tb_id_issue_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  enq_valid = 2'b00;
  logic [63:0] enq_instr = 64'd0;
  logic [63:0] enq_pc = 64'd0;
  logic [27:0] enq_exp = 28'd0;
  logic        enq_ready;
  logic        issue_ready = 1'b0;
  logic [1:0]  issue_valid;
  logic [31:0] Instr_First, PC_First, Instr_Second, PC_Second;
  logic [13:0] Exp_First, Exp_Second;
  logic [4:0]  count;

  id_issue_queue #(.DEPTH(16), .FETCH_W(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_pc(enq_pc), .enq_exp(enq_exp),
    .enq_ready(enq_ready), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .Instr_First(Instr_First), .PC_First(PC_First), .Exp_First(Exp_First),
    .Instr_Second(Instr_Second), .PC_Second(PC_Second), .Exp_Second(Exp_Second),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [13:0] exp;
  } entry_t;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  want;
  } vec_t;

  entry_t      sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] pc_ctr = 32'hBFC0_0000;

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0010};
  endfunction

  function automatic logic [13:0] exp_of(input logic [31:0] pc);
    return pc[15:2] ^ 14'h1A5;
  endfunction

  // Scoreboard: check head slots, then retire issued entries and record accepted lanes.
  always @(negedge clk) begin
    int npop;
    entry_t e;
    if (!resetn) begin
      sb.delete();
    end else begin
      check("count", 64'(count), 64'(sb.size()));
      check("enq_ready", 64'(enq_ready), 64'((16 - sb.size()) >= 2));
      check("valid0", 64'(issue_valid[0]), 64'(sb.size() != 0));
      check("valid1_occ", 64'(issue_valid[1] && (sb.size() < 2)), 64'(0));
      if (sb.size() >= 1) begin
        check("instr_first", 64'(Instr_First), 64'(sb[0].instr));
        check("pc_first", 64'(PC_First), 64'(sb[0].pc));
        check("exp_first", 64'(Exp_First), 64'(sb[0].exp));
      end
      if (sb.size() >= 2) begin
        check("instr_second", 64'(Instr_Second), 64'(sb[1].instr));
        check("pc_second", 64'(PC_Second), 64'(sb[1].pc));
        check("exp_second", 64'(Exp_Second), 64'(sb[1].exp));
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (issue_ready && sb.size() != 0) begin
          npop = issue_valid[1] ? 2 : 1;
          for (int k = 0; k < npop && sb.size() != 0; k++) void'(sb.pop_front());
        end
        if ((16 - sb.size()) >= 2) begin
          for (int l = 0; l < 2; l++) begin
            if (enq_valid[l] && (l == 0 || enq_valid[0])) begin
              e.instr = enq_instr[32*l +: 32];
              e.pc    = enq_pc[32*l +: 32];
              e.exp   = enq_exp[14*l +: 14];
              sb.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input int n, input logic [31:0] i0, input logic [31:0] i1);
    enq_valid = (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
    enq_instr = {i1, i0};
    enq_pc    = {pc_ctr + 32'd4, pc_ctr};
    enq_exp   = {exp_of(pc_ctr + 32'd4), exp_of(pc_ctr)};
    pc_ctr    = pc_ctr + 32'(4 * n);
  endtask

  task automatic idle();
    enq_valid = 2'b00;
  endtask

  task automatic drain();
    issue_ready = 1'b1;
    for (int c = 0; c < 40 && count != 5'd0; c++) step();
    issue_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", 64'(count), 64'(0));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{rtype(1, 2, 3, 6'h21), rtype(4, 6, 5, 6'h21), 2'b11};        // independent addu
    vecs[1] = '{itype(6'h04, 1, 2), rtype(4, 6, 5, 6'h21), 2'b11};           // beq + delay slot
    vecs[2] = '{rtype(4, 6, 5, 6'h21), itype(6'h04, 1, 2), 2'b01};           // branch second
    vecs[3] = '{rtype(1, 2, 0, 6'h18), rtype(0, 0, 7, 6'h12), 2'b01};        // mult, mflo
    vecs[4] = '{rtype(0, 0, 0, 6'h0C), rtype(4, 6, 5, 6'h21), 2'b01};        // syscall first
    vecs[5] = '{rtype(4, 6, 5, 6'h21), rtype(0, 0, 0, 6'h0C), 2'b01};        // syscall second
    vecs[6] = '{itype(6'h23, 1, 8), rtype(8, 2, 9, 6'h21), 2'b01};           // lw dest rt -> rs
    vecs[7] = '{rtype(1, 2, 0, 6'h21), rtype(0, 0, 3, 6'h21), 2'b11};        // dest $0 is none
    vecs[8] = '{itype(6'h03, 0, 0), rtype(4, 31, 5, 6'h21), 2'b01};          // jal writes $31
    vecs[9] = '{rtype(4, 6, 5, 6'h21), rtype(0, 0, 0, 6'h08), 2'b01};        // jr second

    repeat (2) step();
    @(negedge clk);
    check("rst_count", 64'(count), 64'(0));
    check("rst_valid", 64'(issue_valid), 64'(0));
    check("rst_enq_ready", 64'(enq_ready), 64'(1));
    @(posedge clk);
    #1 resetn = 1'b1;

    step();
    drive_enq(2, rtype(1, 2, 3, 6'h21), rtype(4, 6, 5, 6'h21));
    step();
    idle();
    @(negedge clk);
    check("boot_valid", 64'(issue_valid), 64'(2'b11));
    check("boot_pc", 64'(PC_First), 64'(32'hBFC0_0000));
    @(posedge clk);
    #1 issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    @(negedge clk);
    check("boot_drained", 64'(count), 64'(0));

    @(posedge clk);
    #1 drive_enq(2, rtype(1, 2, 3, 6'h21), rtype(3, 1, 4, 6'h23));
    step();
    idle();
    @(negedge clk);
    check("raw_pair", 64'(issue_valid), 64'(2'b01));
    @(posedge clk);
    #1 issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    @(negedge clk);
    check("raw_tail", 64'(issue_valid), 64'(2'b01));
    drain();

    for (int v = 0; v < 10; v++) begin
      @(posedge clk);
      #1 drive_enq(2, vecs[v].i0, vecs[v].i1);
      step();
      idle();
      @(negedge clk);
      check($sformatf("pair_vec%0d", v), 64'(issue_valid), 64'(vecs[v].want));
      drain();
    end

    // Fill to 15 so that enq_ready drops, then hold occupancy while wrapping.
    @(posedge clk);
    #1 drive_enq(1, NOP, NOP);
    for (int i = 0; i < 7; i++) begin
      step();
      drive_enq(2, NOP, NOP);
    end
    step();
    idle();
    @(negedge clk);
    check("full_count", 64'(count), 64'(15));
    check("full_enq_ready", 64'(enq_ready), 64'(0));
    @(posedge clk);
    #1 drive_enq(2, NOP, NOP);
    step();
    idle();
    @(negedge clk);
    check("full_drop", 64'(count), 64'(15));
    @(posedge clk);
    #1 issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    drive_enq(1, NOP, NOP);
    step();
    idle();
    @(negedge clk);
    check("refill_14", 64'(count), 64'(14));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 drive_enq(2, NOP, NOP);
      issue_ready = 1'b1;
      step();
      idle();
      issue_ready = 1'b0;
      @(negedge clk);
      check($sformatf("steady_14_%0d", i), 64'(count), 64'(14));
    end
    drain();

    // Flush while enqueuing and issuing at count 9.
    @(posedge clk);
    #1 drive_enq(1, NOP, NOP);
    for (int i = 0; i < 4; i++) begin
      step();
      drive_enq(2, NOP, NOP);
    end
    step();
    idle();
    @(negedge clk);
    check("pre_flush_count", 64'(count), 64'(9));
    @(posedge clk);
    #1 flush = 1'b1;
    drive_enq(2, NOP, NOP);
    issue_ready = 1'b1;
    step();
    flush = 1'b0;
    issue_ready = 1'b0;
    idle();
    @(negedge clk);
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(issue_valid), 64'(0));
    check("flush_enq_ready", 64'(enq_ready), 64'(1));

    // Asynchronous reset mid-burst at count 6, then resume.
    @(posedge clk);
    #1 drive_enq(2, rtype(1, 2, 3, 6'h21), rtype(4, 6, 5, 6'h21));
    for (int i = 0; i < 2; i++) begin
      step();
      drive_enq(2, rtype(1, 2, 3, 6'h21), rtype(4, 6, 5, 6'h21));
    end
    step();
    check("pre_rst_count", 64'(count), 64'(6));
    resetn = 1'b0;
    #1;
    check("rst_async_count", 64'(count), 64'(0));
    idle();
    repeat (3) step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_enq(2, rtype(1, 2, 3, 6'h21), rtype(4, 6, 5, 6'h21));
      step();
    end
    idle();
    @(negedge clk);
    check("post_rst_count", 64'(count), 64'(8));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
